// File: rtl/host_rx_deframer_pkg.sv
// Shared header field layout, header type codes and parser state encodings
// for the host receive deframer.
package host_rx_deframer_pkg;

    localparam logic [1:0] HDR_T_CMD  = 2'b00;
    localparam logic [1:0] HDR_T_DATA = 2'b01;

    localparam int HDR_TYPE_MSB = 7;
    localparam int HDR_TYPE_LSB = 6;
    localparam int HDR_NW_MSB   = 5;
    localparam int HDR_NW_LSB   = 0;

    localparam int         DATA_W         = 64;
    localparam int         DATA_BYTES     = DATA_W / 8;
    localparam logic [2:0] WORD_LAST_BYTE = 3'd7;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/host_rx_deframer_hs.sv
// Single-entry handshake register: i_load captures i_dat and raises o_vld the same edge,
// o_vld && i_consume clears it. The caller never loads while o_vld is set.
module hs_reg1 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_dat,
    input  logic         i_consume,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
        end else if (r_vld && i_consume) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/host_rx_deframer.sv
// Splits framed host bytes into commands and 64-bit words; outputs rise on the final byte's edge.
// The completing byte is refused while its output register is still full; ERR drops everything.
module host_rx_deframer
    import host_rx_deframer_pkg::*;
#(
    parameter int CMD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_isReady,
    output logic              rx_canReceive,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_hasAny,
    input  logic              cmd_consume,
    output logic [DATA_W-1:0] data,
    output logic              data_isReady,
    input  logic              data_canReceive,
    output logic              frame_err,
    output logic              busy
);

    localparam int         CMD_BYTES = (CMD_W + 7) / 8;
    localparam logic [2:0] CMD_LAST  = 3'(CMD_BYTES - 1);

    state_t r_state;
    state_t w_state_nxt;
    logic [2:0] r_byte_cnt;
    logic [2:0] w_byte_nxt;
    logic [5:0] r_word_cnt;
    logic [5:0] w_word_nxt;

    logic [CMD_BYTES*8-1:0] r_cmd_acc;
    logic [CMD_BYTES*8-1:0] w_cmd_full;
    logic [DATA_W-1:0]      r_data_acc;
    logic [DATA_W-1:0]      w_data_full;

    logic w_fire;
    logic w_cmd_last;
    logic w_word_last;
    logic w_cmd_load;
    logic w_data_load;

    assign w_cmd_last  = (r_state == ST_CMD)  && (r_byte_cnt == CMD_LAST);
    assign w_word_last = (r_state == ST_DATA) && (r_byte_cnt == WORD_LAST_BYTE);

    // Stall depends only on registered state so consume never reaches rx_canReceive combinationally.
    assign rx_canReceive = !rst && !((w_cmd_last && cmd_hasAny) || (w_word_last && data_isReady));
    assign w_fire        = rx_isReady && rx_canReceive;
    assign w_cmd_load    = w_fire && w_cmd_last;
    assign w_data_load   = w_fire && w_word_last;

    always_comb begin
        w_cmd_full = r_cmd_acc;
        for (int i = 0; i < CMD_BYTES; i++) begin
            if (r_byte_cnt == 3'(i)) w_cmd_full[i*8 +: 8] = rx_byte;
        end
        w_data_full = r_data_acc;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (r_byte_cnt == 3'(i)) w_data_full[i*8 +: 8] = rx_byte;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte_cnt;
        w_word_nxt  = r_word_cnt;
        if (w_fire) begin
            case (r_state)
                ST_HDR: begin
                    w_byte_nxt = 3'd0;
                    case (rx_byte[HDR_TYPE_MSB:HDR_TYPE_LSB])
                        HDR_T_CMD:  w_state_nxt = ST_CMD;
                        HDR_T_DATA: begin
                            w_state_nxt = ST_DATA;
                            w_word_nxt  = rx_byte[HDR_NW_MSB:HDR_NW_LSB];
                        end
                        default:    w_state_nxt = ST_ERR;
                    endcase
                end
                ST_CMD: begin
                    if (w_cmd_last) begin
                        w_state_nxt = ST_HDR;
                        w_byte_nxt  = 3'd0;
                    end else begin
                        w_byte_nxt = r_byte_cnt + 3'd1;
                    end
                end
                ST_DATA: begin
                    w_byte_nxt = r_byte_cnt + 3'd1;
                    if (w_word_last) begin
                        if (r_word_cnt == 6'd0) w_state_nxt = ST_HDR;
                        else                    w_word_nxt  = r_word_cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HDR;
            r_byte_cnt <= 3'd0;
            r_word_cnt <= 6'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_nxt;
            r_word_cnt <= w_word_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_acc  <= '0;
            r_data_acc <= '0;
        end else if (w_fire) begin
            if (r_state == ST_CMD)  r_cmd_acc  <= w_cmd_full;
            if (r_state == ST_DATA) r_data_acc <= w_data_full;
        end
    end

    hs_reg1 #(.W(CMD_W)) u_cmd_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_cmd_load),
        .i_dat     (w_cmd_full[CMD_W-1:0]),
        .i_consume (cmd_consume),
        .o_vld     (cmd_hasAny),
        .o_dat     (cmd)
    );

    hs_reg1 #(.W(DATA_W)) u_data_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_data_load),
        .i_dat     (w_data_full),
        .i_consume (data_canReceive),
        .o_vld     (data_isReady),
        .o_dat     (data)
    );

    assign frame_err = (r_state == ST_ERR);
    assign busy      = (r_state == ST_CMD) || (r_state == ST_DATA);

endmodule

// File: tb/tb_host_rx_deframer.sv
// Directed bench for host_rx_deframer: expected outputs are queued by the stimulus
// and popped by a monitor at every output handshake.
module tb_host_rx_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_isReady;
    logic        rx_canReceive;
    logic [15:0] cmd;
    logic        cmd_hasAny;
    logic        cmd_consume;
    logic [63:0] data;
    logic        data_isReady;
    logic        data_canReceive;
    logic        frame_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] cmd_q[$];
    logic [63:0] data_q[$];

    host_rx_deframer #(.CMD_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_byte         (rx_byte),
        .rx_isReady      (rx_isReady),
        .rx_canReceive   (rx_canReceive),
        .cmd             (cmd),
        .cmd_hasAny      (cmd_hasAny),
        .cmd_consume     (cmd_consume),
        .data            (data),
        .data_isReady    (data_isReady),
        .data_canReceive (data_canReceive),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Offer one byte and wait (bounded) until the DUT takes it.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        rx_byte    = b;
        rx_isReady = 1'b1;
        @(negedge clk);
        while (!rx_canReceive && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 64'(b), 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rx_isReady = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic consume_cmd_once();
        cmd_consume = 1'b1;
        @(posedge clk);
        #1;
        cmd_consume = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmd_hasAny && cmd_consume) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", 64'(cmd), 64'hDEAD);
            else                   chk("cmd_out", 64'(cmd), 64'(cmd_q.pop_front()));
        end
        if (data_isReady && data_canReceive) begin
            if (data_q.size() == 0) chk("data_unexpected", data, 64'hDEAD);
            else                    chk("data_out", data, data_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        rx_byte         = 8'h00;
        rx_isReady      = 1'b0;
        cmd_consume     = 1'b0;
        data_canReceive = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_canReceive", 64'(rx_canReceive), 64'd0);
        chk("rst_cmd_hasAny", 64'(cmd_hasAny), 64'd0);
        chk("rst_data_isReady", 64'(data_isReady), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd", 64'(cmd), 64'd0);
        chk("rst_data", data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_canReceive", 64'(rx_canReceive), 64'd1);
        cycles(1);

        // CMD frame, held for several cycles before consume
        cmd_q.push_back(16'h1234);
        send(8'h00);
        chk("cmd_busy", 64'(busy), 64'd1);
        send(8'h34);
        chk("cmd_not_yet", 64'(cmd_hasAny), 64'd0);
        send(8'h12);
        chk("cmd_latency", 64'(cmd_hasAny), 64'd1);
        chk("cmd_busy_done", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            chk("cmd_hold", 64'(cmd), 64'h1234);
            chk("cmd_hold_vld", 64'(cmd_hasAny), 64'd1);
        end
        consume_cmd_once();
        chk("cmd_cleared", 64'(cmd_hasAny), 64'd0);

        // DATA frame of 2 words, sink always ready
        data_canReceive = 1'b1;
        data_q.push_back(64'h0807060504030201);
        data_q.push_back(64'h1817161514131211);
        send(8'h41);
        for (int i = 1; i <= 8; i++) send(8'(i));
        for (int i = 1; i <= 7; i++) send(8'(8'h10 + i));
        chk("data_busy_b16", 64'(busy), 64'd1);
        send(8'h18);
        chk("data_busy_b17", 64'(busy), 64'd0);
        cycles(2);
        chk("data_q_drained", 64'(data_q.size()), 64'd0);

        // Back-pressure on the data output
        data_canReceive = 1'b0;
        data_q.push_back(64'h2827262524232221);
        data_q.push_back(64'h3837363534333231);
        send(8'h41);
        for (int i = 1; i <= 8; i++) send(8'(8'h20 + i));
        for (int i = 1; i <= 7; i++) send(8'(8'h30 + i));
        chk("bp_word1_held", data, 64'h2827262524232221);
        chk("bp_word1_vld", 64'(data_isReady), 64'd1);
        rx_byte    = 8'h38;
        rx_isReady = 1'b1;
        @(negedge clk);
        chk("bp_stall", 64'(rx_canReceive), 64'd0);
        @(posedge clk);
        #1;
        data_canReceive = 1'b1;
        send(8'h38);
        cycles(3);
        chk("bp_q_drained", 64'(data_q.size()), 64'd0);

        // Full cmd register does not block a DATA frame
        cmd_q.push_back(16'hABCD);
        send(8'h00); send(8'hCD); send(8'hAB);
        data_q.push_back(64'h5857565554535251);
        send(8'h40);
        for (int i = 1; i <= 8; i++) send(8'(8'h50 + i));
        cycles(2);
        chk("ind_data_delivered", 64'(data_q.size()), 64'd0);
        chk("ind_cmd_still", 64'(cmd_hasAny), 64'd1);
        cmd_q.push_back(16'hBEEF);
        send(8'h00); send(8'hEF);
        rx_byte    = 8'hBE;
        rx_isReady = 1'b1;
        @(negedge clk);
        chk("ind_cmd_stall", 64'(rx_canReceive), 64'd0);
        @(posedge clk);
        #1;
        consume_cmd_once();
        send(8'hBE);
        chk("ind_cmd2_vld", 64'(cmd_hasAny), 64'd1);
        chk("ind_cmd2_val", 64'(cmd), 64'hBEEF);
        consume_cmd_once();
        chk("ind_cmd_q", 64'(cmd_q.size()), 64'd0);

        // Reserved header puts the parser in a sticky error state
        send(8'h80);
        chk("err_set", 64'(frame_err), 64'd1);
        send(8'h00); send(8'h34); send(8'h12);
        cycles(1);
        chk("err_drop", 64'(cmd_hasAny), 64'd0);
        chk("err_canReceive", 64'(rx_canReceive), 64'd1);
        chk("err_sticky", 64'(frame_err), 64'd1);
        rst = 1'b1;
        #1;
        chk("err_rst_clear", 64'(frame_err), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-frame discards partial frame and both output registers
        send(8'h00); send(8'h11); send(8'h22);
        send(8'h41); send(8'h61); send(8'h62); send(8'h63);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_cmd_vld", 64'(cmd_hasAny), 64'd0);
        chk("mid_cmd", 64'(cmd), 64'd0);
        chk("mid_data_vld", 64'(data_isReady), 64'd0);
        chk("mid_data", data, 64'd0);
        chk("mid_busy_rst", 64'(busy), 64'd0);
        chk("mid_canReceive", 64'(rx_canReceive), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cmd_q.push_back(16'h5678);
        send(8'h00); send(8'h78); send(8'h56);
        chk("mid_cmd_after", 64'(cmd), 64'h5678);
        consume_cmd_once();

        cycles(3);
        chk("final_cmd_q", 64'(cmd_q.size()), 64'd0);
        chk("final_data_q", 64'(data_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
